mem_initiator: RTL and testbench

Host-side memory initiator: accepts block read/write commands (start word address, word count) and issues one word request per cycle on the scratchpad's memory request/response port. It streams write data in and read data out over valid/ready handshakes. It sits between the host-target interface logic and a free port of the scratchpad memory. It replaces ad-hoc host loading with a single sequenced engine.

---
 rtl/mem_initiator_if.sv | 69 ++++++
 rtl/mem_initiator.sv | 181 ++++++++++++++++++
 tb/tb_mem_initiator.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator_if
// Description : Bundles the command, write-stream, read-stream, status and
//               scratchpad request/response signals of the memory initiator.
//               The master modport is the initiator's view. The slave modport
//               is the view of the host logic and memory around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_initiator_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 16
);
  // Command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;

  // Write data stream (host -> engine)
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] wdata;

  // Read data stream (engine -> host)
  logic          rdata_valid;
  logic          rdata_ready;
  logic [DW-1:0] rdata;

  // Status
  logic          busy;
  logic          done;

  // Scratchpad request/response port
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic          mem_req_fcn;
  logic [2:0]    mem_req_typ;
  logic [DW-1:0] mem_resp_data;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
    input  wdata_valid, wdata,
    input  rdata_ready,
    input  mem_req_ready, mem_resp_data,
    output cmd_ready,
    output wdata_ready,
    output rdata_valid, rdata,
    output busy, done,
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len,
    output wdata_valid, wdata,
    output rdata_ready,
    output mem_req_ready, mem_resp_data,
    input  cmd_ready,
    input  wdata_ready,
    input  rdata_valid, rdata,
    input  busy, done,
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ
  );
endinterface
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator
// Description : Block read/write engine for a scratchpad memory port.
//               It accepts a command (start address, word count) and issues
//               one word request per cycle. Write data streams straight
//               through to the memory. Read data is captured into a single
//               output register and handed to the host over valid/ready.
// Options     : MEM_INITIATOR_ABORT_EN - adds an 'abort' input. It ends a
//               running block early, after the last completed word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_initiator #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int LW = 16
) (
  input wire             clk,
  input wire             rst_n,
`ifdef MEM_INITIATOR_ABORT_EN
  input wire             abort,
`endif
  mem_initiator_if.master bus
);

  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_RUN     = 2'd1;
  localparam logic [1:0]    S_DONE    = 2'd2;

  // Word alignment mask and per-word address increment
  localparam logic [AW-1:0] ADDR_MASK = ~(AW'(SW - 1));
  localparam logic [AW-1:0] ADDR_STEP = AW'(SW);
  // Full-word access size code
  localparam logic [2:0]    REQ_TYP   = 3'(SW - 1);

  logic [1:0]    state_q, state_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic          abort_req;
  logic          cmd_accept;
  logic          in_run;
  logic          req_valid;
  logic          mem_hs;
  logic          last_word;

`ifdef MEM_INITIATOR_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign cmd_accept = (state_q == S_IDLE) && bus.cmd_valid;
  assign in_run     = (state_q == S_RUN);
  assign mem_hs     = req_valid && bus.mem_req_ready;
  assign last_word  = (cnt_q == LW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = (bus.cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // An abort ends the block immediately. Otherwise the block ends on
        // the final word's handshake.
        if (abort_req || (mem_hs && last_word)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Completion waits until the host has taken the last read word
        if (!rvalid_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: the request port is driven only while a block is running
  always_comb begin
    req_valid         = 1'b0;
    bus.wdata_ready   = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_data  = '0;
    bus.mem_req_fcn   = 1'b0;
    bus.mem_req_typ   = 3'd0;
    if (in_run) begin
      bus.mem_req_addr = addr_q;
      bus.mem_req_typ  = REQ_TYP;
      if (wr_q) begin
        // Write: pure pass-through of the host stream into the memory port
        bus.mem_req_fcn  = 1'b1;
        bus.mem_req_data = bus.wdata;
        req_valid        = bus.wdata_valid && !abort_req;
        bus.wdata_ready  = bus.mem_req_ready && !abort_req;
      end else begin
        // Read: request only if the output register is free or being drained
        req_valid = (!rvalid_q || bus.rdata_ready) && !abort_req;
      end
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.cmd_ready     = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE) && !rvalid_q;
  assign bus.rdata_valid   = rvalid_q;
  assign bus.rdata         = rdata_q;

  // Datapath next values: command capture, address/count stepping, read buffer
  always_comb begin
    wr_d     = wr_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;

    if (cmd_accept) begin
      wr_d   = bus.cmd_wr;
      addr_d = bus.cmd_addr & ADDR_MASK;
      cnt_d  = bus.cmd_len;
    end

    if (mem_hs) begin
      // Address wraps silently at the top of the address space
      addr_d = addr_q + ADDR_STEP;
      cnt_d  = cnt_q - LW'(1);
    end

    if (in_run && abort_req) begin
      cnt_d = '0;
    end

    if (rvalid_q && bus.rdata_ready) begin
      rvalid_d = 1'b0;
    end

    // A refill in the same cycle as a drain keeps the buffer valid
    if (mem_hs && !wr_q) begin
      rdata_d  = bus.mem_resp_data;
      rvalid_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_initiator
// Description : Self-checking bench for mem_initiator. It uses a table of
//               full-rate commands with hand-computed expectations, directed
//               stall/reset/abort sequences and randomized commands. All of
//               these are compared against an address/data reference model.
//               Define MEM_INITIATOR_ABORT_EN to also cover the abort input.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_initiator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef MEM_INITIATOR_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_initiator_if #(.AW(32), .DW(32), .LW(16)) bus ();

  mem_initiator #(.AW(32), .DW(32), .SW(4), .LW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MEM_INITIATOR_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous memory contents: a fixed function of the address
  function automatic logic [31:0] rd_pattern(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_1234;
  endfunction

  assign bus.mem_resp_data = rd_pattern(bus.mem_req_addr);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fcn;
    logic [2:0]  typ;
    int          c;
  } req_t;

  req_t        mlog[$];
  logic [31:0] rlog[$];
  logic [31:0] wlist[$];
  int          widx;

  // Observers: memory handshakes and delivered read words
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_req_valid && bus.mem_req_ready)
        mlog.push_back('{bus.mem_req_addr, bus.mem_req_data, bus.mem_req_fcn, bus.mem_req_typ, cyc});
      if (bus.rdata_valid && bus.rdata_ready)
        rlog.push_back(bus.rdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_env(input int mode);
    if (mode == 0) begin
      bus.mem_req_ready = 1'b1;
      bus.wdata_valid   = 1'b1;
      bus.rdata_ready   = 1'b1;
    end else begin
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      bus.wdata_valid   = ($urandom_range(0, 3) != 0);
      bus.rdata_ready   = ($urandom_range(0, 2) != 0);
    end
    bus.wdata = (widx < wlist.size()) ? wlist[widx] : 32'h0;
  endtask

  // Offer a command in the next cycle; returns the accept cycle number
  task automatic issue(input bit wr, input logic [31:0] a, input logic [15:0] len, output int acc);
    wlist.delete();
    for (int i = 0; i < int'(len); i++) wlist.push_back($urandom);
    widx = 0;
    mlog.delete();
    rlog.delete();
    @(posedge clk); #1;
    bus.cmd_valid     = 1'b1;
    bus.cmd_wr        = wr;
    bus.cmd_addr      = a;
    bus.cmd_len       = len;
    bus.mem_req_ready = 1'b0;
    bus.wdata_valid   = 1'b0;
    bus.rdata_ready   = 1'b0;
    bus.wdata         = (wlist.size() > 0) ? wlist[0] : 32'h0;
    #1;
    acc = cyc;
    chk("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
  endtask

  // Run the environment until done (lat = cycles since accept), or until
  // stop_at memory words have been transferred (lat = -2)
  task automatic run_until_done(input int acc, input int mode, input int stop_at, output int lat);
    bit hs;
    lat = -1;
    for (int t = 0; t < 2000; t++) begin
      hs = bus.wdata_valid && bus.wdata_ready;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if (hs) widx++;
      drive_env(mode);
      #1;
      if (bus.done) begin
        lat = cyc - acc;
        return;
      end
      if (stop_at > 0 && int'(mlog.size()) == stop_at) begin
        lat = -2;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL run_timeout actual=no_done required=done_within_2000_cycles");
  endtask

  task automatic post_done();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    #1;
    chk("done_one_cycle", {31'b0, bus.done}, 32'd0);
    chk("cmd_ready_after", {31'b0, bus.cmd_ready}, 32'd1);
    chk("busy_after", {31'b0, bus.busy}, 32'd0);
  endtask

  // Reference model: word i of a block goes to aligned_base + 4*i (mod 2^32)
  task automatic check_cmd(input bit wr, input logic [31:0] a, input int len);
    logic [31:0] base;
    logic [31:0] ea;
    int          n;
    base = a & 32'hFFFF_FFFC;
    chk("req_count", mlog.size(), len);
    n = (int'(mlog.size()) < len) ? int'(mlog.size()) : len;
    for (int i = 0; i < n; i++) begin
      ea = base + 32'(i * 4);
      chk("req_addr", mlog[i].addr, ea);
      chk("req_fcn", {31'b0, mlog[i].fcn}, {31'b0, wr});
      chk("req_typ", {29'b0, mlog[i].typ}, 32'd3);
      if (wr) chk("req_data", mlog[i].data, wlist[i]);
    end
    if (!wr) begin
      chk("rd_count", rlog.size(), len);
      n = (int'(rlog.size()) < len) ? int'(rlog.size()) : len;
      for (int i = 0; i < n; i++) chk("rd_data", rlog[i], rd_pattern(base + 32'(i * 4)));
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [15:0] len;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int acc;
    int lat;

    tbl[0] = '{1'b1, 32'h0000_0100, 16'd4, 32'h0000_0100, 32'h0000_010C, 5};
    tbl[1] = '{1'b1, 32'hFFFF_FFFC, 16'd2, 32'hFFFF_FFFC, 32'h0000_0000, 3};
    tbl[2] = '{1'b1, 32'h0000_0103, 16'd1, 32'h0000_0100, 32'h0000_0100, 2};
    tbl[3] = '{1'b0, 32'h0000_0040, 16'd0, 32'h0,         32'h0,         1};
    tbl[4] = '{1'b1, 32'h0000_0080, 16'd0, 32'h0,         32'h0,         1};
    tbl[5] = '{1'b0, 32'h0000_0200, 16'd3, 32'h0000_0200, 32'h0000_0208, 5};
    tbl[6] = '{1'b0, 32'h0000_0007, 16'd1, 32'h0000_0004, 32'h0000_0004, 3};

    bus.cmd_valid     = 1'b0;
    bus.cmd_wr        = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_len       = '0;
    bus.wdata_valid   = 1'b0;
    bus.wdata         = '0;
    bus.rdata_ready   = 1'b0;
    bus.mem_req_ready = 1'b0;
    widx              = 0;

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_rdata_valid", {31'b0, bus.rdata_valid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_mem_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("rst_wdata_ready", {31'b0, bus.wdata_ready}, 32'd0);
    chk("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;

    // ---- table: full-rate commands ----
    for (int v = 0; v < 7; v++) begin
      issue(tbl[v].wr, tbl[v].addr, tbl[v].len, acc);
      run_until_done(acc, 0, 0, lat);
      chk("tbl_done_latency", lat, tbl[v].exp_lat);
      chk("tbl_busy_at_done", {31'b0, bus.busy}, 32'd1);
      if (tbl[v].len != 0 && mlog.size() == int'(tbl[v].len)) begin
        chk("tbl_first_addr", mlog[0].addr, tbl[v].exp_first);
        chk("tbl_last_addr", mlog[mlog.size()-1].addr, tbl[v].exp_last);
        chk("tbl_first_req_lat", mlog[0].c - acc, 32'd1);
        chk("tbl_throughput", mlog[mlog.size()-1].c - mlog[0].c, 32'(tbl[v].len - 1));
      end
      check_cmd(tbl[v].wr, tbl[v].addr, int'(tbl[v].len));
      post_done();
    end

    // ---- read with host back-pressure on the first word ----
    issue(1'b0, 32'h0000_0200, 16'd3, acc);
    @(posedge clk); #1;
    bus.cmd_valid     = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.rdata_ready   = 1'b0;
    #1;
    chk("stall_first_req", {31'b0, bus.mem_req_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk("stall_rdata_valid", {31'b0, bus.rdata_valid}, 32'd1);
      chk("stall_rdata_held", bus.rdata, rd_pattern(32'h0000_0200));
      chk("stall_req_dropped", {31'b0, bus.mem_req_valid}, 32'd0);
      chk("stall_no_done", {31'b0, bus.done}, 32'd0);
    end
    run_until_done(acc, 0, 0, lat);
    chk("stall_done_latency", lat, 8);
    check_cmd(1'b0, 32'h0000_0200, 3);
    post_done();

    // ---- asynchronous reset in the middle of a read ----
    issue(1'b0, 32'h0000_0300, 16'd8, acc);
    run_until_done(acc, 0, 3, lat);
    chk("rstmid_reached", lat, -2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rstmid_busy", {31'b0, bus.busy}, 32'd0);
    chk("rstmid_done", {31'b0, bus.done}, 32'd0);
    chk("rstmid_rdata_valid", {31'b0, bus.rdata_valid}, 32'd0);
    chk("rstmid_rdata", bus.rdata, 32'd0);
    chk("rstmid_mem_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("rstmid_mem_req_addr", bus.mem_req_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rstmid_no_more_reqs", mlog.size(), 32'd3);
    chk("rstmid_idle_after", {31'b0, bus.busy}, 32'd0);
    issue(1'b1, 32'h0000_0500, 16'd3, acc);
    run_until_done(acc, 0, 0, lat);
    chk("rstmid_clean_latency", lat, 4);
    check_cmd(1'b1, 32'h0000_0500, 3);
    post_done();

`ifdef MEM_INITIATOR_ABORT_EN
    // ---- abort a write after four words ----
    issue(1'b1, 32'h0000_0400, 16'd10, acc);
    run_until_done(acc, 0, 4, lat);
    chk("abort_reached", lat, -2);
    abort = 1'b1;
    #1;
    chk("abort_gates_req", {31'b0, bus.mem_req_valid}, 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    chk("abort_done", {31'b0, bus.done}, 32'd1);
    chk("abort_no_req", {31'b0, bus.mem_req_valid}, 32'd0);
    post_done();
    check_cmd(1'b1, 32'h0000_0400, 4);
`endif

    // ---- randomized commands with random stalls ----
    for (int r = 0; r < 25; r++) begin
      bit          wr;
      logic [31:0] a;
      logic [15:0] len;
      wr  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      len = 16'($urandom_range(0, 12));
      issue(wr, a, len, acc);
      run_until_done(acc, 1, 0, lat);
      check_cmd(wr, a, int'(len));
      post_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
